lsu_bus_ctrl: RTL

- Load/store unit that consumes the 4-bit memory-op code produced by the instruction decoder and executes it as a multi-cycle transaction on a valid/ready data bus.
- Sits between the execute stage and data memory.
- Formats store data and byte strobes, extracts and extends load data, and stalls the core until the access completes, faults, or times out.

---
 rtl/lsu_bus_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: turns a decoded mem op into one valid/ready bus
// transaction, formats store data/strobes, extracts load data, stalls the core.
module lsu_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  CTRL_i_mem_rw,
  input  logic        LSU_i_req,
  input  logic [31:0] EXE_i_valE,
  input  logic [31:0] REG_i_valB,
  output logic        LSU_o_stall,
  output logic        LSU_o_done,
  output logic        LSU_o_err,
  output logic [31:0] LSU_o_valM,
  output logic        BUS_o_valid,
  output logic        BUS_o_we,
  output logic [31:0] BUS_o_addr,
  output logic [31:0] BUS_o_wdata,
  output logic [3:0]  BUS_o_wstrb,
  input  logic        BUS_i_ready,
  input  logic [31:0] BUS_i_rdata
);
  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_e;

  localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                         OP_LW = 4'd5, OP_SB  = 4'd6, OP_SH = 4'd7, OP_SW  = 4'd8;
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC - 1);
  localparam bit         TO_EN  = (TIMEOUT_CYC != 0);

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] valm_q, valm_d;

  logic        op_ok, misalign, is_store;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      valm_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      valm_q  <= valm_d;
    end
  end

  always_comb begin
    op_ok    = LSU_i_req && (CTRL_i_mem_rw >= OP_LB) && (CTRL_i_mem_rw <= OP_SW);
    misalign = 1'b0;
    case (CTRL_i_mem_rw)
      OP_LH, OP_LHU, OP_SH: misalign = EXE_i_valE[0];
      OP_LW, OP_SW:         misalign = (EXE_i_valE[1:0] != 2'b00);
      default:              misalign = 1'b0;
    endcase
    is_store = (op_q >= OP_SB);
    // Lane select uses the byte offset captured at issue, not the live address.
    ld_byte  = BUS_i_rdata[{off_q, 3'b000} +: 8];
    ld_half  = BUS_i_rdata[{off_q[1], 4'b0000} +: 16];
    case (op_q)
      OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_data = {24'd0, ld_byte};
      OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_data = {16'd0, ld_half};
      OP_LW:   ld_data = BUS_i_rdata;
      default: ld_data = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    off_d   = off_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    valm_d  = valm_q;
    unique case (state_q)
      S_IDLE: begin
        err_d  = 1'b0;
        valm_d = '0;
        if (op_ok) begin
          if (misalign) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            op_d    = CTRL_i_mem_rw;
            off_d   = EXE_i_valE[1:0];
            addr_d  = {EXE_i_valE[31:2], 2'b00};
            cnt_d   = '0;
            state_d = S_BUS;
            case (CTRL_i_mem_rw)
              OP_SB: begin
                wdata_d = {4{REG_i_valB[7:0]}};
                wstrb_d = 4'b0001 << EXE_i_valE[1:0];
              end
              OP_SH: begin
                wdata_d = {2{REG_i_valB[15:0]}};
                wstrb_d = 4'b0011 << {EXE_i_valE[1], 1'b0};
              end
              OP_SW: begin
                wdata_d = REG_i_valB;
                wstrb_d = 4'b1111;
              end
              default: begin
                wdata_d = '0;
                wstrb_d = 4'b0000;
              end
            endcase
          end
        end
      end
      S_BUS: begin
        // Ready has priority over a timeout landing in the same cycle.
        if (BUS_i_ready) begin
          err_d   = 1'b0;
          valm_d  = is_store ? 32'd0 : ld_data;
          state_d = S_DONE;
        end else if (TO_EN && (cnt_q == TO_LIM)) begin
          err_d   = 1'b1;
          valm_d  = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        err_d   = 1'b0;
        valm_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    BUS_o_valid = (state_q == S_BUS);
    BUS_o_we    = BUS_o_valid & is_store;
    BUS_o_addr  = BUS_o_valid ? addr_q  : 32'd0;
    BUS_o_wdata = BUS_o_valid ? wdata_q : 32'd0;
    BUS_o_wstrb = BUS_o_valid ? wstrb_q : 4'b0000;
    LSU_o_stall = ((state_q == S_IDLE) & op_ok) | BUS_o_valid;
    LSU_o_done  = (state_q == S_DONE);
    LSU_o_err   = LSU_o_done & err_q;
    LSU_o_valM  = LSU_o_done ? valm_q : 32'd0;
  end
endmodule
